// File: rtl/value_exchanger.sv
// value_exchanger: swaps one word between agents A and B over valid/ready channels.
module value_exchanger #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in_valid,
  output logic             a_in_ready,
  input  logic [WIDTH-1:0] a_in_data,
  input  logic             b_in_valid,
  output logic             b_in_ready,
  input  logic [WIDTH-1:0] b_in_data,
  output logic             a_out_valid,
  input  logic             a_out_ready,
  output logic [WIDTH-1:0] a_out_data,
  output logic             b_out_valid,
  input  logic             b_out_ready,
  output logic [WIDTH-1:0] b_out_data,
  output logic             busy,
  output logic [CNT_W-1:0] xchg_count
);
  typedef enum logic [1:0] {EMPTY, GOT_A, GOT_B, DELIVER} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic a_fire, b_fire, enter;
  assign a_in_ready = state == EMPTY || state == GOT_B;
  assign b_in_ready = state == EMPTY || state == GOT_A;
  assign a_fire = a_in_valid && a_in_ready;
  assign b_fire = b_in_valid && b_in_ready;
  assign enter = state != DELIVER && state_nx == DELIVER;
  assign a_out_data = reg_b;
  assign b_out_data = reg_a;
  assign busy = state != EMPTY;
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = a_fire && b_fire ? DELIVER : a_fire ? GOT_A : b_fire ? GOT_B : EMPTY;
      GOT_A:   state_nx = b_fire ? DELIVER : GOT_A;
      GOT_B:   state_nx = a_fire ? DELIVER : GOT_B;
      DELIVER: state_nx = (a_out_valid && !a_out_ready) || (b_out_valid && !b_out_ready) ? DELIVER : EMPTY;
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      reg_a       <= '0;
      reg_b       <= '0;
      a_out_valid <= 1'b0;
      b_out_valid <= 1'b0;
      xchg_count  <= '0;
    end else begin
      state <= state_nx;
      if (a_fire) reg_a <= a_in_data;
      if (b_fire) reg_b <= b_in_data;
      a_out_valid <= enter || (a_out_valid && !a_out_ready);
      b_out_valid <= enter || (b_out_valid && !b_out_ready);
      if (enter) xchg_count <= xchg_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_value_exchanger.sv
// tb_value_exchanger: directed checks of the value_exchanger handshake, reset and counter wrap.
module tb_value_exchanger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in_valid = 1'b0, b_in_valid = 1'b0, a_out_ready = 1'b0, b_out_ready = 1'b0;
  logic [7:0] a_in_data = '0, b_in_data = '0;
  logic a_in_ready, b_in_ready, a_out_valid, b_out_valid, busy;
  logic [7:0] a_out_data, b_out_data;
  logic [3:0] xchg_count;
  int errors = 0;
  int checks = 0;

  value_exchanger #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_data(a_in_data),
    .b_in_valid(b_in_valid), .b_in_ready(b_in_ready), .b_in_data(b_in_data),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_data(a_out_data),
    .b_out_valid(b_out_valid), .b_out_ready(b_out_ready), .b_out_data(b_out_data),
    .busy(busy), .xchg_count(xchg_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic va, input logic [7:0] da, input logic vb, input logic [7:0] db);
    a_in_valid = va; a_in_data = da; b_in_valid = vb; b_in_data = db;
    step();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
  endtask

  task automatic accept(input logic ra, input logic rb);
    a_out_ready = ra; b_out_ready = rb;
    step();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({a_out_valid, b_out_valid} !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", {a_out_valid, b_out_valid}); end
    checks++; if ({a_out_data, b_out_data} !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", {a_out_data, b_out_data}); end
    checks++; if (xchg_count !== 4'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", xchg_count); end
    checks++; if ({a_in_ready, b_in_ready} !== 2'b11) begin errors++; $display("FAIL reset_in_ready got=%b exp=11", {a_in_ready, b_in_ready}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_a_first();
    offer(1'b1, 8'h3C, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({a_in_ready, b_in_ready, busy} !== 3'b011) begin errors++; $display("FAIL got_a_ready_busy[%0d] got=%b exp=011", i, {a_in_ready, b_in_ready, busy}); end
      checks++; if ({a_out_valid, b_out_valid} !== 2'b00) begin errors++; $display("FAIL got_a_out_valid[%0d] got=%b exp=00", i, {a_out_valid, b_out_valid}); end
      step();
    end
    offer(1'b0, 8'h00, 1'b1, 8'hA5);
    checks++; if ({a_out_valid, b_out_valid} !== 2'b11) begin errors++; $display("FAIL a_first_valid got=%b exp=11", {a_out_valid, b_out_valid}); end
    checks++; if (a_out_data !== 8'hA5) begin errors++; $display("FAIL a_first_a_out got=%h exp=a5", a_out_data); end
    checks++; if (b_out_data !== 8'h3C) begin errors++; $display("FAIL a_first_b_out got=%h exp=3c", b_out_data); end
    checks++; if (xchg_count !== 4'h1) begin errors++; $display("FAIL a_first_count got=%h exp=1", xchg_count); end
    accept(1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a_first_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    offer(1'b1, 8'h11, 1'b1, 8'h22);
    checks++; if ({a_out_data, b_out_data} !== 16'h2211) begin errors++; $display("FAIL simul_data got=%h exp=2211", {a_out_data, b_out_data}); end
    checks++; if ({a_out_valid, b_out_valid, busy} !== 3'b111) begin errors++; $display("FAIL simul_valid_busy got=%b exp=111", {a_out_valid, b_out_valid, busy}); end
    checks++; if (xchg_count !== 4'h2) begin errors++; $display("FAIL simul_count got=%h exp=2", xchg_count); end
    accept(1'b1, 1'b1);
    checks++; if ({busy, a_out_valid, b_out_valid} !== 3'b000) begin errors++; $display("FAIL simul_done got=%b exp=000", {busy, a_out_valid, b_out_valid}); end
    checks++; if ({a_in_ready, b_in_ready} !== 2'b11) begin errors++; $display("FAIL simul_ready_back got=%b exp=11", {a_in_ready, b_in_ready}); end
  endtask

  task automatic test_stagger();
    offer(1'b1, 8'h11, 1'b1, 8'h22);
    accept(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({a_out_valid, b_out_valid} !== 2'b01) begin errors++; $display("FAIL stagger_valid[%0d] got=%b exp=01", i, {a_out_valid, b_out_valid}); end
      checks++; if (b_out_data !== 8'h11) begin errors++; $display("FAIL stagger_b_data[%0d] got=%h exp=11", i, b_out_data); end
      checks++; if ({a_in_ready, b_in_ready, busy} !== 3'b001) begin errors++; $display("FAIL stagger_ready_busy[%0d] got=%b exp=001", i, {a_in_ready, b_in_ready, busy}); end
      if (i < 3) step();
    end
    accept(1'b0, 1'b1);
    checks++; if ({b_out_valid, busy} !== 2'b00) begin errors++; $display("FAIL stagger_done got=%b exp=00", {b_out_valid, busy}); end
    checks++; if ({a_in_ready, b_in_ready} !== 2'b11) begin errors++; $display("FAIL stagger_ready_back got=%b exp=11", {a_in_ready, b_in_ready}); end
  endtask

  task automatic test_backpressure();
    offer(1'b1, 8'h5A, 1'b0, 8'h00);
    a_in_valid = 1'b1; a_in_data = 8'hFF;
    repeat (2) step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready got=%b exp=0", a_in_ready); end
    a_in_valid = 1'b0;
    offer(1'b0, 8'h00, 1'b1, 8'h66);
    checks++; if (b_out_data !== 8'h5A) begin errors++; $display("FAIL bp_b_out got=%h exp=5a", b_out_data); end
    checks++; if (a_out_data !== 8'h66) begin errors++; $display("FAIL bp_a_out got=%h exp=66", a_out_data); end
    accept(1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    offer(1'b1, 8'h77, 1'b1, 8'h88);
    checks++; if ({a_out_valid, b_out_valid} !== 2'b11) begin errors++; $display("FAIL ar_pre_valid got=%b exp=11", {a_out_valid, b_out_valid}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_out_valid, b_out_valid, busy} !== 3'b000) begin errors++; $display("FAIL ar_drop got=%b exp=000", {a_out_valid, b_out_valid, busy}); end
    checks++; if (xchg_count !== 4'h0) begin errors++; $display("FAIL ar_count got=%h exp=0", xchg_count); end
    checks++; if ({a_out_data, b_out_data} !== 16'h0) begin errors++; $display("FAIL ar_data got=%h exp=0000", {a_out_data, b_out_data}); end
    step();
    rst_n = 1'b1;
    step();
    offer(1'b1, 8'h01, 1'b1, 8'h02);
    checks++; if ({a_out_data, b_out_data} !== 16'h0201) begin errors++; $display("FAIL ar_fresh_data got=%h exp=0201", {a_out_data, b_out_data}); end
    checks++; if (xchg_count !== 4'h1) begin errors++; $display("FAIL ar_fresh_count got=%h exp=1", xchg_count); end
    accept(1'b1, 1'b1);
  endtask

  task automatic test_count_wrap();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] exp;
      exp = 4'(i);
      offer(1'b1, 8'(i), 1'b1, 8'(i + 100));
      checks++; if (xchg_count !== exp) begin errors++; $display("FAIL wrap_count[%0d] got=%h exp=%h", i, xchg_count, exp); end
      accept(1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_a_first();
    test_simultaneous();
    test_stagger();
    test_backpressure();
    test_async_reset();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/value_exchanger.md
Name: value_exchanger

Overview:
- Race-free, deterministic exchange of two values between two independent agents, A and B.
- Each agent offers one word over a valid/ready input channel. Once both words are captured, each agent receives the other's word over its own valid/ready output channel.
- Replaces ad-hoc cross-assignment between concurrent processes with one clocked owner for both registers.
- Sits between two producer/consumer agents in the test infrastructure and datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 16, width of the completed-exchange counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_in_valid  input  1  agent A offers a_in_data.
- a_in_ready  output  1  exchanger can capture A's word.
- a_in_data  input  WIDTH  A's offered word.
- b_in_valid  input  1  agent B offers b_in_data.
- b_in_ready  output  1  exchanger can capture B's word.
- b_in_data  input  WIDTH  B's offered word.
- a_out_valid  output  1  word for A (B's captured word) is available.
- a_out_ready  input  1  A accepts a_out_data.
- a_out_data  output  WIDTH  B's captured word.
- b_out_valid  output  1  word for B (A's captured word) is available.
- b_out_ready  input  1  B accepts b_out_data.
- b_out_data  output  WIDTH  A's captured word.
- busy  output  1  state is not EMPTY.
- xchg_count  output  CNT_W  number of completed captures of a pair.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is held in registers clocked on the rising edge of clk.
- Reset values: state=EMPTY; reg_a=0 and reg_b=0; a_out_valid=0 and b_out_valid=0; a_out_data=0 and b_out_data=0; busy=0; xchg_count=0.
- Handshake: a transfer happens on a rising edge where valid && ready. Ready is a pure function of state and never depends on the same-cycle valid. Once out_valid is asserted, it and its data stay stable until accepted.
- States:
  - EMPTY: a_in_ready=1, b_in_ready=1.
    - Only A fires: capture reg_a, go to GOT_A.
    - Only B fires: capture reg_b, go to GOT_B.
    - Both fire in the same cycle: capture both, go to DELIVER.
  - GOT_A: a_in_ready=0, b_in_ready=1. B fires: capture reg_b, go to DELIVER.
  - GOT_B: b_in_ready=0, a_in_ready=1. A fires: capture reg_a, go to DELIVER.
  - DELIVER: both in_ready=0.
    - On entry: a_out_valid=1 and b_out_valid=1, with a_out_data=reg_b and b_out_data=reg_a.
    - Each out_valid clears independently on its own transfer.
    - When the last pending output transfers (or both transfer in the same cycle), go to EMPTY.
- Latency: outputs are valid on the cycle after the edge that captures the second word. There is no combinational path from in to out.
- EMPTY is re-entered one cycle after the final output acceptance. No new capture occurs in the same cycle as the final delivery.
- xchg_count: increments by 1 on each transition into DELIVER. Wraps from 2^CNT_W-1 to 0 with no saturation.
- busy = (state != EMPTY).
- Data stability:
  - reg_a and reg_b change only on their own input transfer.
  - Input data is ignored while ready=0, even if valid=1.
- Reset mid-operation: rst_n low in any state returns everything to the reset values immediately. Pending outputs are dropped with no partial delivery, and xchg_count clears.
- Invalid state encodings recover to EMPTY.

Test Plan:
- Reset, then A offers 0x3C while B stays idle for 5 cycles: a_in_ready=0 from the next cycle, no out_valid, busy=1. B then offers 0xA5: next cycle a_out_data=0xA5, b_out_data=0x3C, both out_valid=1, xchg_count=1.
- Simultaneous offer in EMPTY, A=0x11 and B=0x22 on the same edge: next cycle a_out_data=0x22, b_out_data=0x11. Both outputs accepted on the same edge: state EMPTY and busy=0 one cycle later.
- Staggered acceptance: a_out_ready high, b_out_ready held low for 4 cycles. a_out_valid drops after its transfer. b_out_valid and b_out_data=0x11 stay stable. Both in_ready stay 0 until B accepts, then return to 1 the cycle after.
- Back-pressure on inputs: in GOT_A, drive a_in_valid=1 with 0xFF. reg_a is unchanged and the exchange later delivers the original A word.
- Reset asserted asynchronously mid-DELIVER: out_valids drop to 0 without a clock edge, xchg_count=0, state EMPTY. A fresh exchange of 0x01 and 0x02 then completes correctly.
- Counter wrap: with CNT_W=4, run 17 exchanges. xchg_count reads 0xF after 15, 0x0 after 16 and 0x1 after 17.
